// File: rtl/circular_dma_pkg.sv
// Shared types and constants for the circular DMA message packer.
package circular_dma_pkg;

    // Packer FSM: waiting for a message, collecting payload, emitting trailer.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;

    // Placement of the byte-length field inside the trailer word.
    localparam int TRAILER_LEN_LSB   = 0;
    localparam int TRAILER_LEN_WIDTH = 32;

    localparam logic [TRAILER_LEN_WIDTH-1:0] LEN_MAX = '1;

    // Length counter increment that sticks at all-ones instead of wrapping,
    // so an oversized message reports "huge" rather than a small bogus value.
    function automatic logic [TRAILER_LEN_WIDTH-1:0] sat_inc(
        input logic [TRAILER_LEN_WIDTH-1:0] v
    );
        return (v == LEN_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/circular_dma_msg_packer.sv
// Packs byte-wide tlast-delimited messages into C_AXIS_WIDTH-bit words,
// zero-pads the last payload word and appends a trailer word holding the
// message byte length (trailer is the only word with m_axis_tlast set).
module circular_dma_msg_packer
    import circular_dma_pkg::*;
#(
    parameter int C_AXIS_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [C_AXIS_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [31:0]             msg_count,
    output logic                    busy
);

    localparam int N     = C_AXIS_WIDTH / 8;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N - 1);

    state_t                          r_state;
    logic [C_AXIS_WIDTH-1:0]         r_acc;
    logic [IDX_W-1:0]                r_idx;
    logic [TRAILER_LEN_WIDTH-1:0]    r_len;
    logic [C_AXIS_WIDTH-1:0]         r_out_data;
    logic                            r_out_last;
    logic                            r_out_valid;
    logic [31:0]                     r_msg_count;
    logic                            r_busy;

    logic                            w_out_free;
    logic                            w_s_ready;
    logic                            w_accept;
    logic                            w_word_done;
    logic                            w_load_trailer;
    logic                            w_trailer_hs;
    logic [C_AXIS_WIDTH-1:0]         w_merged;
    logic [C_AXIS_WIDTH-1:0]         w_trailer;

    // Single output register: it can be refilled in the same cycle it drains.
    assign w_out_free = ~r_out_valid | m_axis_tready;

    // Upstream ready depends on state; enable only gates the start of a message.
    always_comb begin
        w_s_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE:    w_s_ready = enable & w_out_free;
                ST_PAYLOAD: w_s_ready = w_out_free;
                default:    w_s_ready = 1'b0;
            endcase
        end
    end

    assign w_accept       = s_axis_tvalid & w_s_ready;
    assign w_word_done    = w_accept & ((r_idx == LAST_LANE) | s_axis_tlast);
    assign w_load_trailer = (r_state == ST_TRAILER) & w_out_free;
    assign w_trailer_hs   = r_out_valid & r_out_last & m_axis_tready;

    // Accumulator with the incoming byte dropped into lane r_idx; lanes above
    // r_idx are still zero because the accumulator clears after every word.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign w_merged[gi*8 +: 8] = (r_idx == IDX_W'(gi)) ? s_axis_tdata
                                                               : r_acc[gi*8 +: 8];
        end
    endgenerate

    // Trailer word: byte length in the low field, all other bits zero.
    always_comb begin
        w_trailer = '0;
        w_trailer[TRAILER_LEN_LSB +: TRAILER_LEN_WIDTH] = r_len;
    end

    // Message FSM, lane index, accumulator and running byte length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_len   <= '0;
        end else begin
            if (w_accept) begin
                r_len <= sat_inc(r_len);
                if (w_word_done) begin
                    r_acc <= '0;
                    r_idx <= '0;
                end else begin
                    r_acc <= w_merged;
                    r_idx <= r_idx + 1'b1;
                end
                r_state <= s_axis_tlast ? ST_TRAILER : ST_PAYLOAD;
            end
            if (w_load_trailer) begin
                r_len   <= '0;
                r_state <= ST_IDLE;
            end
        end
    end

    // Output register: payload words take priority (they cannot coincide with
    // a trailer load because input is stalled in ST_TRAILER); held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_out_free) begin
            if (w_word_done) begin
                r_out_data  <= w_merged;
                r_out_last  <= 1'b0;
                r_out_valid <= 1'b1;
            end else if (w_load_trailer) begin
                r_out_data  <= w_trailer;
                r_out_last  <= 1'b1;
                r_out_valid <= 1'b1;
            end else begin
                r_out_last  <= 1'b0;
                r_out_valid <= 1'b0;
            end
        end
    end

    // Message counter and busy flag; a new message starting on the same edge
    // as the previous trailer handshake keeps busy high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg_count <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (w_trailer_hs) begin
                r_msg_count <= r_msg_count + 32'd1;
            end
            if (w_accept && (r_state == ST_IDLE)) begin
                r_busy <= 1'b1;
            end else if (w_trailer_hs) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_valid;
    assign msg_count     = r_msg_count;
    assign busy          = r_busy;

endmodule

// File: tb/tb_circular_dma_msg_packer.sv
// Bench for circular_dma_msg_packer: directed scenarios plus random messages
// checked against a per-message word list built from byte counts.
module tb_circular_dma_msg_packer;

    localparam int W = 64;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [7:0]   s_axis_tdata = '0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic [31:0]  msg_count;
    logic         busy;

    logic [W:0]   exp_q[$];
    logic [W:0]   obs_q[$];
    int           total = 0;
    int           bad = 0;
    int           exp_msgs = 0;
    bit           rand_ready = 1'b0;
    logic         ready_val = 1'b1;

    circular_dma_msg_packer #(.C_AXIS_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .msg_count     (msg_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Downstream ready driver: fixed level or coin-flip per cycle.
    always @(posedge clk) begin
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        else            m_axis_tready = ready_val;
    end

    // Output monitor: one line per output handshake.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tlast, m_axis_tdata});
            $display("out word data=%h last=%0d", m_axis_tdata, m_axis_tlast);
        end
    end

    // Global watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    // Reference: split the message into 8-byte little-endian words, pad the
    // final partial word with zeros, then one trailer word carrying the length.
    function automatic void model_msg(input bq_t m);
        int L = m.size();
        int nw = (L + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            logic [W-1:0] d = '0;
            for (int k = 0; k < 8; k++)
                if (w * 8 + k < L) d[k*8 +: 8] = m[w*8 + k];
            exp_q.push_back({1'b0, d});
        end
        exp_q.push_back({1'b1, 64'(L)});
        exp_msgs++;
    endfunction

    // Present one byte and hold it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!s_axis_tready) begin
            bad++;
            $display("FAIL byte_accept_timeout got=stalled want=accepted data=%h", d);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_msg(input bq_t m, input int gap_max);
        for (int i = 0; i < m.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            send_byte(m[i], (i == m.size() - 1));
        end
    endtask

    // Wait (bounded) until n output words were seen, then settle a few cycles.
    task automatic wait_obs(input int n);
        int c = 0;
        while (obs_q.size() < n && c < 2000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {s_axis_tready, m_axis_tvalid, m_axis_tlast, busy});
        end
        total++;
        if (m_axis_tdata !== '0 || msg_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_values got data=%h cnt=%0d want 0/0", m_axis_tdata, msg_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready got=%b want=1", s_axis_tready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bq_t m;
        exp_q.delete(); obs_q.delete();
        m = '{8'h11, 8'h22, 8'h33};
        model_msg(m);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0000000000332211 || m_axis_tlast !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency got v=%b d=%h l=%b want 1/0000000000332211/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy got=%b want=1", busy);
        end
        wait_obs(2);
        total++;
        if (msg_count !== 32'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_count got cnt=%0d busy=%b want 1/0", msg_count, busy);
        end
        m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        model_msg(m);
        send_msg(m, 0);
        total++;
        if (m_axis_tdata !== 64'h0807060504030201) begin
            bad++;
            $display("FAIL full_word got=%h want=0807060504030201", m_axis_tdata);
        end
        wait_obs(4);
        m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        model_msg(m);
        send_msg(m, 0);
        wait_obs(7);
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL basic_words got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            logic [W:0] got = (i < obs_q.size()) ? obs_q[i] : {(W+1){1'bx}};
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_word%0d got=%h want=%h", i, got, exp_q[i]);
            end
        end
        total++;
        if (msg_count !== 32'(exp_msgs)) begin
            bad++;
            $display("FAIL basic_msgcount got=%0d want=%0d", msg_count, exp_msgs);
        end
    endtask

    task automatic test_backpressure();
        bq_t m;
        exp_q.delete(); obs_q.delete();
        m = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        model_msg(m);
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_byte(m[i], 1'b0);
        s_axis_tdata  = 8'h09;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0807060504030201) begin
                bad++;
                $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h want 0/1/0807060504030201", c, s_axis_tready, m_axis_tvalid, m_axis_tdata);
            end
        end
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        send_byte(8'h09, 1'b1);
        wait_obs(3);
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL bp_words got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            logic [W:0] got = (i < obs_q.size()) ? obs_q[i] : {(W+1){1'bx}};
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_word%0d got=%h want=%h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_enable();
        bq_t m;
        exp_q.delete(); obs_q.delete();
        enable = 1'b0;
        s_axis_tdata = 8'hAA; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                bad++;
                $display("FAIL en_idle%0d got rdy=%b v=%b want 0/0", c, s_axis_tready, m_axis_tvalid);
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        enable = 1'b1;
        m = '{8'h41, 8'h42, 8'h43, 8'h44};
        model_msg(m);
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        enable = 1'b0;
        send_byte(8'h43, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_obs(2);
        s_axis_tdata = 8'h55; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (s_axis_tready !== 1'b0) begin
                bad++;
                $display("FAIL en_holdoff%0d got=%b want=0", c, s_axis_tready);
            end
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        m = '{8'h55};
        model_msg(m);
        send_byte(8'h55, 1'b1);
        wait_obs(4);
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL en_words got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            logic [W:0] got = (i < obs_q.size()) ? obs_q[i] : {(W+1){1'bx}};
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL en_word%0d got=%h want=%h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bq_t m;
        exp_q.delete(); obs_q.delete();
        ready_val = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), 1'b0);
        total++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rm_pre got v=%b busy=%b want 1/1", m_axis_tvalid, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_msgs = 0;
        @(negedge clk);
        total++;
        if (m_axis_tvalid !== 1'b0 || msg_count !== 32'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rm_after got v=%b cnt=%0d busy=%b want 0/0/0", m_axis_tvalid, msg_count, busy);
        end
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        @(posedge clk);
        #1;
        m = '{8'hE1, 8'hE2};
        model_msg(m);
        send_msg(m, 0);
        wait_obs(2);
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rm_words got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            logic [W:0] got = (i < obs_q.size()) ? obs_q[i] : {(W+1){1'bx}};
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL rm_word%0d got=%h want=%h", i, got, exp_q[i]);
            end
        end
        total++;
        if (msg_count !== 32'd1) begin
            bad++;
            $display("FAIL rm_count got=%0d want=1", msg_count);
        end
    endtask

    task automatic test_random();
        exp_q.delete(); obs_q.delete();
        rand_ready = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 40; n++) begin
            bq_t m;
            int len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            model_msg(m);
            send_msg(m, 2);
        end
        wait_obs(exp_q.size());
        rand_ready = 1'b0;
        total++;
        if (obs_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rnd_words got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            logic [W:0] got = (i < obs_q.size()) ? obs_q[i] : {(W+1){1'bx}};
            total++;
            if (got !== exp_q[i]) begin
                bad++;
                $display("FAIL rnd_word%0d got=%h want=%h", i, got, exp_q[i]);
            end
        end
        total++;
        if (msg_count !== 32'(exp_msgs) || busy !== 1'b0) begin
            bad++;
            $display("FAIL rnd_count got cnt=%0d busy=%b want %0d/0", msg_count, busy, exp_msgs);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
